// File: rtl/core_pkg.sv
// core_pkg: instruction bit positions, mode FSM states and err flag indices
// shared by core_inst_ctrl and its field decoder.
package core_pkg;

    localparam int B_DEBUG     = 63;
    localparam int B_L1_WR     = 37;
    localparam int B_MODE      = 36;
    localparam int B_REN_P     = 35;
    localparam int B_SFU       = 34;
    localparam int B_ACC       = 33;
    localparam int B_CEN_P     = 32;
    localparam int B_WEN_P     = 31;
    localparam int B_AP_LO     = 20;
    localparam int B_CEN_X     = 19;
    localparam int B_WEN_X     = 18;
    localparam int B_AX_LO     = 7;
    localparam int B_OFIFO_RD  = 6;
    localparam int B_IFIFO_WR  = 5;
    localparam int B_IFIFO_RD  = 4;
    localparam int B_L0_RD     = 3;
    localparam int B_L0_WR     = 2;
    localparam int B_EXEC      = 1;
    localparam int B_LOAD      = 0;

    localparam int ERR_MODE      = 2;
    localparam int ERR_CONFLICT  = 1;
    localparam int ERR_UNDERFLOW = 0;

    typedef enum logic [1:0] {RUN, ACTIVE, DRAIN} state_t;

endpackage

// File: rtl/inst_field_decode.sv
// inst_field_decode: combinational field extraction, mode routing of the array
// bits, and conflict/underflow detection with strobe suppression.
module inst_field_decode
    import core_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [63:0]       i_inst,
    input  logic              i_mode_os,
    input  logic              i_ofifo_valid,
    output logic [ADDR_W-1:0] o_a_xmem,
    output logic [ADDR_W-1:0] o_a_pmem,
    output logic              o_ififo_wr,
    output logic              o_l0_wr,
    output logic              o_l1_wr,
    output logic              o_ofifo_rd,
    output logic              o_ws_execute,
    output logic              o_ws_load,
    output logic              o_os_pass_psum,
    output logic              o_os_accumulate,
    output logic              o_conflict,
    output logic              o_underflow,
    output logic [2:0]        o_drops
);
    logic w_fill_clash;
    logic w_both_ws;
    logic w_unused;

    assign w_unused = ^{i_inst[63:38], i_inst[36:31], i_inst[4:3]};

    always_comb begin
        o_a_xmem        = i_inst[B_AX_LO +: ADDR_W];
        o_a_pmem        = i_inst[B_AP_LO +: ADDR_W];
        // an xmem write owns the read-data path, so no fill may ride along
        w_fill_clash    = !i_inst[B_CEN_X] && !i_inst[B_WEN_X]
                          && (i_inst[B_L0_WR] || i_inst[B_L1_WR] || i_inst[B_IFIFO_WR]);
        w_both_ws       = !i_mode_os && i_inst[B_EXEC] && i_inst[B_LOAD];
        o_ififo_wr      = i_inst[B_IFIFO_WR] && !w_fill_clash;
        o_l0_wr         = i_inst[B_L0_WR] && !w_fill_clash;
        o_l1_wr         = i_inst[B_L1_WR] && !w_fill_clash && i_mode_os;
        o_ofifo_rd      = i_inst[B_OFIFO_RD] && i_ofifo_valid;
        o_ws_execute    = !i_mode_os && i_inst[B_EXEC] && !i_inst[B_LOAD];
        o_ws_load       = !i_mode_os && i_inst[B_LOAD];
        o_os_pass_psum  = i_mode_os && i_inst[B_EXEC];
        o_os_accumulate = i_mode_os && i_inst[B_LOAD];
        o_conflict      = w_fill_clash || (!i_mode_os && i_inst[B_L1_WR]) || w_both_ws;
        o_underflow     = i_inst[B_OFIFO_RD] && !i_ofifo_valid;
        o_drops         = {2'b0, i_inst[B_IFIFO_WR] && !o_ififo_wr}
                        + {2'b0, i_inst[B_L0_WR] && !o_l0_wr}
                        + {2'b0, i_inst[B_L1_WR] && !o_l1_wr}
                        + {2'b0, o_underflow}
                        + {2'b0, w_both_ws};
    end

endmodule

// File: rtl/core_inst_ctrl.sv
// core_inst_ctrl: registers and decodes the 64-bit core instruction, owns the WS/OS
// mode FSM and sticky errors. CORE_INST_CTRL_PERF_EN adds op_cnt/drop_cnt counters.
module core_inst_ctrl
    import core_pkg::*;
#(
    parameter int ADDR_W        = 11,
    parameter int DRAIN_CYC     = 16,
    parameter bit RESET_MODE_OS = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       inst,
    input  logic              ofifo_valid,
    output logic              CEN_xmem,
    output logic              WEN_xmem,
    output logic              CEN_pmem,
    output logic              WEN_pmem,
    output logic [ADDR_W-1:0] A_xmem,
    output logic [ADDR_W-1:0] A_pmem,
    output logic              REN_pmem,
    output logic              acc,
    output logic              sfu_passthrough,
    output logic              debug,
    output logic              ofifo_rd,
    output logic              ififo_rd,
    output logic              l0_rd,
    output logic              ififo_wr,
    output logic              l0_wr,
    output logic              l1_wr,
    output logic              ws_execute,
    output logic              ws_load,
    output logic              os_pass_psum,
    output logic              os_accumulate,
    output logic              mode_os,
    output logic              busy,
`ifdef CORE_INST_CTRL_PERF_EN
    output logic [31:0]       op_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic [2:0]        err
);
    localparam int CW = $clog2(DRAIN_CYC + 1);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [2:0]        r_fill;
    logic              w_op, w_mode_nxt;
    logic [2:0]        w_err_set;
    logic [ADDR_W-1:0] w_a_xmem, w_a_pmem;
    logic              w_ififo_wr, w_l0_wr, w_l1_wr, w_ofifo_rd;
    logic              w_ws_execute, w_ws_load, w_os_pass_psum, w_os_accumulate;
    logic              w_conflict, w_underflow;
    logic [2:0]        w_drops;

    assign w_op = inst[B_EXEC] || inst[B_LOAD];

    inst_field_decode #(.ADDR_W(ADDR_W)) u_dec (
        .i_inst          (inst),
        .i_mode_os       (w_mode_nxt),
        .i_ofifo_valid   (ofifo_valid),
        .o_a_xmem        (w_a_xmem),
        .o_a_pmem        (w_a_pmem),
        .o_ififo_wr      (w_ififo_wr),
        .o_l0_wr         (w_l0_wr),
        .o_l1_wr         (w_l1_wr),
        .o_ofifo_rd      (w_ofifo_rd),
        .o_ws_execute    (w_ws_execute),
        .o_ws_load       (w_ws_load),
        .o_os_pass_psum  (w_os_pass_psum),
        .o_os_accumulate (w_os_accumulate),
        .o_conflict      (w_conflict),
        .o_underflow     (w_underflow),
        .o_drops         (w_drops)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            mode_os <= RESET_MODE_OS;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            mode_os <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_op) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = CW'(DRAIN_CYC);
        end else if (r_state == ACTIVE) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = CW'(DRAIN_CYC);
        end else if (r_state == DRAIN) begin
            w_state_nxt = (r_cnt == '0) ? RUN : DRAIN;
            w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
    end

    // a mode change commits only from RUN and then governs this same instruction
    always_comb begin
        busy                    = r_state != RUN;
        w_mode_nxt              = busy ? mode_os : inst[B_MODE];
        w_err_set               = '0;
        w_err_set[ERR_MODE]     = busy && (inst[B_MODE] != mode_os);
        w_err_set[ERR_CONFLICT] = w_conflict;
        w_err_set[ERR_UNDERFLOW] = w_underflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            CEN_xmem        <= 1'b1;
            WEN_xmem        <= 1'b1;
            CEN_pmem        <= 1'b1;
            WEN_pmem        <= 1'b1;
            A_xmem          <= '0;
            A_pmem          <= '0;
            REN_pmem        <= 1'b0;
            acc             <= 1'b0;
            sfu_passthrough <= 1'b0;
            debug           <= 1'b0;
            ofifo_rd        <= 1'b0;
            ififo_rd        <= 1'b0;
            l0_rd           <= 1'b0;
            ws_execute      <= 1'b0;
            ws_load         <= 1'b0;
            os_pass_psum    <= 1'b0;
            os_accumulate   <= 1'b0;
            r_fill          <= '0;
            {l1_wr, l0_wr, ififo_wr} <= '0;
            err             <= '0;
        end else begin
            CEN_xmem        <= inst[B_CEN_X];
            WEN_xmem        <= inst[B_WEN_X];
            CEN_pmem        <= inst[B_CEN_P];
            WEN_pmem        <= inst[B_WEN_P];
            A_xmem          <= w_a_xmem;
            A_pmem          <= w_a_pmem;
            REN_pmem        <= inst[B_REN_P];
            acc             <= inst[B_ACC];
            sfu_passthrough <= inst[B_SFU];
            debug           <= inst[B_DEBUG];
            ofifo_rd        <= w_ofifo_rd;
            ififo_rd        <= inst[B_IFIFO_RD];
            l0_rd           <= inst[B_L0_RD];
            ws_execute      <= w_ws_execute;
            ws_load         <= w_ws_load;
            os_pass_psum    <= w_os_pass_psum;
            os_accumulate   <= w_os_accumulate;
            // fills wait one extra cycle for the xmem read data
            r_fill          <= {w_l1_wr, w_l0_wr, w_ififo_wr};
            {l1_wr, l0_wr, ififo_wr} <= r_fill;
            err             <= err | w_err_set;
        end
    end

`ifdef CORE_INST_CTRL_PERF_EN
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, drop_cnt} + 17'(w_drops);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if ((ws_execute || ws_load || os_pass_psum || os_accumulate) && op_cnt != '1)
                op_cnt <= op_cnt + 1'b1;
            drop_cnt <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_core_inst_ctrl.sv
// tb_core_inst_ctrl: directed test-plan scenarios plus randomized instructions
// checked against a cycle-indexed behavioural model of the instruction controller.
module tb_core_inst_ctrl;

    localparam int DRAIN_CYC = 16;
    localparam logic [63:0] L0W = 64'h4;
    localparam logic [63:0] L1W = 64'h1 << 37;
    localparam logic [63:0] OFR = 64'h40;
    localparam logic [63:0] EXE = 64'h2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] inst;
    logic        ofifo_valid;
    logic        CEN_xmem, WEN_xmem, CEN_pmem, WEN_pmem;
    logic [10:0] A_xmem, A_pmem;
    logic        REN_pmem, acc, sfu_passthrough, debug;
    logic        ofifo_rd, ififo_rd, l0_rd, ififo_wr, l0_wr, l1_wr;
    logic        ws_execute, ws_load, os_pass_psum, os_accumulate;
    logic        mode_os, busy;
    logic [2:0]  err;
`ifdef CORE_INST_CTRL_PERF_EN
    logic [31:0] op_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    core_inst_ctrl #(.ADDR_W(11), .DRAIN_CYC(DRAIN_CYC), .RESET_MODE_OS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .ofifo_valid(ofifo_valid),
        .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem),
        .A_xmem(A_xmem), .A_pmem(A_pmem), .REN_pmem(REN_pmem), .acc(acc),
        .sfu_passthrough(sfu_passthrough), .debug(debug), .ofifo_rd(ofifo_rd),
        .ififo_rd(ififo_rd), .l0_rd(l0_rd), .ififo_wr(ififo_wr), .l0_wr(l0_wr),
        .l1_wr(l1_wr), .ws_execute(ws_execute), .ws_load(ws_load),
        .os_pass_psum(os_pass_psum), .os_accumulate(os_accumulate),
        .mode_os(mode_os), .busy(busy),
`ifdef CORE_INST_CTRL_PERF_EN
        .op_cnt(op_cnt), .drop_cnt(drop_cnt),
`endif
        .err(err)
    );

    int checks = 0;
    int errors = 0;

    // model state: instruction index, last array-op index, mode, sticky errors
    int         k = 0;
    int         last_op = -1000;
    logic       m_mode = 1'b1;
    logic [2:0] m_err = '0;
    logic [2:0] m_fill_prev = '0;
    int         m_ops = 0;
    int         m_drops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] idle(input logic m);
        return 64'h0000_0001_800C_0000 | (64'(m) << 36);
    endfunction

    function automatic logic [63:0] xop(input logic m, input logic cen, input logic wen,
                                        input logic [10:0] a, input logic [63:0] ex);
        logic [63:0] r;
        r = idle(m);
        r[19] = cen;
        r[18] = wen;
        r[17:7] = a;
        return r | ex;
    endfunction

    function automatic logic in_window(input int idx);
        return (idx - last_op) >= 1 && (idx - last_op) <= DRAIN_CYC + 2;
    endfunction

    task automatic model_reset();
        m_mode = 1'b1;
        m_err = '0;
        m_fill_prev = '0;
        last_op = k - 1000;
        m_ops = 0;
        m_drops = 0;
    endtask

    task automatic step(input logic [63:0] in, input logic v);
        logic        m, clash, ofr, both;
        logic [2:0]  fill;
        logic [3:0]  arr;
        logic [36:0] exp1;
        int          drops;
        inst = in;
        ofifo_valid = v;
        if (!in_window(k)) m_mode = in[36];
        else if (in[36] != m_mode) m_err[2] = 1'b1;
        m = m_mode;
        clash = !in[19] && !in[18] && (in[2] || in[5] || in[37]);
        fill = {in[37] && !clash && m, in[2] && !clash, in[5] && !clash};
        ofr = in[6] && v;
        if (in[6] && !v) m_err[0] = 1'b1;
        both = !m && in[1] && in[0];
        arr = m ? {2'b00, in[1], in[0]} : {in[1] && !in[0], in[0], 2'b00};
        if (clash || (!m && in[37]) || both) m_err[1] = 1'b1;
        drops = int'(in[5] && !fill[0]) + int'(in[2] && !fill[1]) + int'(in[37] && !fill[2])
              + int'(in[6] && !ofr) + int'(both);
        if (in[1] || in[0]) last_op = k;
        k++;
        @(posedge clk);
        #1;
        exp1 = {in[19], in[18], in[17:7], in[32], in[31], in[30:20], in[35], in[33], in[34],
                in[63], ofr, in[4], in[3], arr};
        chk("lat1", {CEN_xmem, WEN_xmem, A_xmem, CEN_pmem, WEN_pmem, A_pmem, REN_pmem, acc,
                     sfu_passthrough, debug, ofifo_rd, ififo_rd, l0_rd, ws_execute, ws_load,
                     os_pass_psum, os_accumulate}, exp1);
        chk("fill", {l1_wr, l0_wr, ififo_wr}, m_fill_prev);
        chk("mode", mode_os, m);
        chk("busy", busy, in_window(k));
        chk("err", err, m_err);
`ifdef CORE_INST_CTRL_PERF_EN
        m_drops += drops;
        chk("op_cnt", op_cnt, m_ops);
        chk("drop_cnt", drop_cnt, m_drops);
        if (arr != 0) m_ops++;
`else
        if (drops < 0) m_drops = drops;
`endif
        m_fill_prev = fill;
    endtask

    initial begin
        logic [63:0] r;
        reset_n = 1'b0;
        inst = idle(1'b1);
        ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cen", {CEN_xmem, WEN_xmem, CEN_pmem, WEN_pmem}, 4'hF);
        chk("rst_mode", mode_os, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_fill", {l1_wr, l0_wr, ififo_wr}, 0);
        reset_n = 1'b1;
        model_reset();

        step(xop(1, 0, 0, 11'd0, 0), 0);
        step(xop(1, 0, 0, 11'd575, 0), 0);
        chk("wr575_a", A_xmem, 575);
        chk("wr575_en", {CEN_xmem, WEN_xmem}, 0);
        step(idle(1), 0);
        chk("wr_l0", l0_wr, 0);

        step(xop(1, 0, 1, 11'd576, L1W), 0);
        chk("l1_early", l1_wr, 0);
        step(idle(1), 0);
        chk("l1_lat2", l1_wr, 1);
        chk("l1_err", err, 0);
        step(idle(1), 0);
        chk("l1_off", l1_wr, 0);

        step(idle(0), 0);
        chk("to_ws", mode_os, 0);
        repeat (4) step(idle(0) | EXE, 0);
        chk("ws_exec", ws_execute, 1);
        step(idle(0), 0);
        step(idle(1), 0);
        chk("mode_err", err[2], 1);
        chk("mode_kept", mode_os, 0);
        repeat (16) step(idle(0), 0);
        step(idle(1), 0);
        chk("mode_retry", mode_os, 1);

        step(xop(1, 0, 0, 11'd5, L0W), 0);
        chk("cf_wen", WEN_xmem, 0);
        chk("cf_err", err[1], 1);
        step(idle(1), 0);
        chk("cf_l0", l0_wr, 0);

        step(idle(1) | OFR, 0);
        chk("uf_rd", ofifo_rd, 0);
        chk("uf_err", err[0], 1);
        step(idle(1) | OFR, 1);
        chk("of_rd", ofifo_rd, 1);

        for (int i = 0; i < 1500; i++) begin
            r = {$urandom(), $urandom()};
            if ($urandom_range(0, 15) != 0) r[1:0] = 2'b00;
            r[36] = ($urandom_range(0, 7) == 0) ? !m_mode : m_mode;
            step(r, 1'($urandom_range(0, 1)));
        end

        step(xop(m_mode, 0, 1, 11'd10, L0W | EXE), 0);
        step(xop(m_mode, 0, 1, 11'd11, L0W | EXE), 0);
        chk("mb_l0_pre", l0_wr, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mb_l0", l0_wr, 0);
        chk("mb_cen", CEN_xmem, 1);
`ifdef CORE_INST_CTRL_PERF_EN
        chk("mb_opcnt", op_cnt, 0);
`endif
        inst = idle(1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        step(idle(1), 0);
        step(idle(1), 0);
        chk("mb_lost", l0_wr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_inst_ctrl.md
# core_inst_ctrl

Core-side consumer of the 64-bit instruction word that the core testbench drives into `core`. It registers the word, decodes its fields into SRAM, FIFO, L0/L1 and array controls, and aligns buffer-fill strobes with the 1-cycle xmem read latency. It owns the weight-stationary/output-stationary mode, and it guards mode switches and illegal field combinations. It sits at the top of `core`, between the `inst` port and the datapath.

## Interface
- `ADDR_W`, 11: width of the xmem and pmem address fields.
- `DRAIN_CYC`, 16: idle cycles required after the last array op before a mode switch is accepted (row+col).
- `RESET_MODE_OS`, 1: mode after reset (1 = output stationary).
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `inst` in 64: instruction word (bit map under Operation).
- `ofifo_valid` in 1: the ofifo holds a full row.
- `CEN_xmem`, `WEN_xmem`, `CEN_pmem`, `WEN_pmem` out 1 each: SRAM enables, active-low.
- `A_xmem`, `A_pmem` out ADDR_W each: SRAM addresses.
- `REN_pmem`, `acc`, `sfu_passthrough`, `debug` out 1 each: passthrough controls.
- `ofifo_rd`, `ififo_rd`, `l0_rd` out 1 each: FIFO read strobes.
- `ififo_wr`, `l0_wr`, `l1_wr` out 1 each: fill strobes, aligned to xmem read data.
- `ws_execute`, `ws_load`, `os_pass_psum`, `os_accumulate` out 1 each: array ops.
- `mode_os` out 1: current mode.
- `busy` out 1: an array op is in flight or the drain window is open.
- `err` out 3: sticky flags `{mode_err, conflict_err, underflow_err}`.

## Operation
- Bit map:
  - 63 debug; 37 l1_wr; 36 output_stationary; 35 REN_pmem; 34 sfu_passthrough; 33 acc.
  - 32 CEN_pmem; 31 WEN_pmem; 30:20 A_pmem.
  - 19 CEN_xmem; 18 WEN_xmem; 17:7 A_xmem.
  - 6 ofifo_rd; 5 ififo_wr; 4 ififo_rd; 3 l0_rd; 2 l0_wr; 1 execute/pass_psum; 0 load/accumulate.
  - Bits 62:38 are reserved and ignored.
- Bits 1:0 are routed by `mode_os`:
  - OS mode: to `os_pass_psum` / `os_accumulate`.
  - WS mode: to `ws_execute` / `ws_load`.
  - The array outputs of the inactive mode stay 0.
- Mode FSM states:
  - RUN: no op pending. A mode bit different from `mode_os` commits to the new mode in the next cycle.
  - ACTIVE: any array op bit is set. A mode bit different from `mode_os` sets `mode_err`; the mode is kept.
  - DRAIN: a down-counter loaded with DRAIN_CYC when ACTIVE is left. A mismatching mode bit sets `mode_err`. At 0 the FSM goes to RUN.
  - An array op during DRAIN reloads the counter and returns the FSM to ACTIVE.
  - `busy` = state != RUN.
- Conflicts set `conflict_err` and suppress the offending strobes:
  - xmem write (CEN=0, WEN=0) together with any of l0_wr, l1_wr, ififo_wr: all three strobes are dropped; the SRAM write proceeds.
  - l1_wr in WS mode: l1_wr is dropped.
  - Both array bits set in WS mode: `ws_load` wins.
- `ofifo_rd` while `ofifo_valid` is 0: the strobe is suppressed and `underflow_err` is set.
- `err` bits clear only on reset.

## Timing
- Reset values:
  - `CEN_*` and `WEN_*` = 1.
  - `mode_os` = RESET_MODE_OS; FSM = RUN.
  - All other outputs 0.
- Latency 1 (inst at edge N, output valid after edge N+1): SRAM controls and addresses, read strobes, array ops, `acc`, `sfu_passthrough`, `REN_pmem`, `debug`.
- Latency 2: `ififo_wr`, `l0_wr`, `l1_wr`, so the write lands on the same cycle as the xmem Q data.
- A mode switch accepted at inst edge N: the new `mode_os` is visible after edge N+1. Array bits in that same instruction are decoded under the new mode.
- The `ofifo_valid` check uses the value sampled at the same edge as `inst`.
- reset_n asserted mid-burst: every pipeline stage clears immediately and pending fill strobes are lost.

## Configuration
- `CORE_INST_CTRL_PERF_EN` defined:
  - Adds outputs `op_cnt` (32 bits, counts cycles with any array op out) and `drop_cnt` (16 bits, counts suppressed strobes).
  - Both counters saturate and reset to 0.
- Undefined: the ports and the counters are absent.

## Structure
- Package `core_pkg`:
  - bit-position localparams for every instruction field;
  - FSM state enum {RUN, ACTIVE, DRAIN};
  - err bit indices.
- Sub-module `inst_field_decode`: purely combinational field extraction and conflict detection. The top module holds the pipeline, the FSM and the counters.

## Test plan
- Reset, then drive an xmem write at address 0 and address 575 with `inst[19:18]`=00 → `CEN_xmem`/`WEN_xmem`=0 and `A_xmem`=575 one cycle later; `l0_wr` stays 0.
- xmem read at address 576 (CEN=0, WEN=1) with l1_wr=1 in OS mode → `l1_wr` high exactly 2 cycles after `inst`; `err`=000.
- In WS mode, drive `ws_execute` for 4 cycles, then flip bit 36 one cycle later → `mode_err` set and `mode_os` stays 0. Retry after 16 idle cycles → `mode_os`=1 one cycle after the retry instruction.
- Drive `inst[19:18]`=00 together with l0_wr=1 → `conflict_err` set, `l0_wr` never asserted, SRAM write still issued (`WEN_xmem`=0).
- Drive ofifo_rd=1 with `ofifo_valid`=0 → `ofifo_rd` stays 0 and `err[0]`=1. With `ofifo_valid`=1 → `ofifo_rd` pulses after 1 cycle.
- Assert reset_n low while l0_wr is in the pipeline → `l0_wr`=0 immediately and `CEN_xmem`=1; with PERF_EN, `op_cnt`=0.
